inference_sequencer: RTL and testbench

INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

---
 rtl/inference_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_inference_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inference_sequencer.sv
// Avalon-MM controlled sequencer: launches accelerator layers, then picks the argmax digit from the score stream.
// Optional watchdog abort on stalled WAIT/ARGMAX is compiled in with INFER_TIMEOUT_EN.
module inference_sequencer (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               acc_start,
  output logic [1:0]         acc_layer,
  input  logic               acc_done,
  input  logic               score_valid,
  input  logic [3:0]         score_idx,
  input  logic signed [15:0] score,
  output logic [3:0]         digit_out,
  output logic               irq
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    WAIT   = 3'd2,
    ARGMAX = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_RESULT = 2'd2;
  localparam logic [1:0] ADDR_LAYERS = 2'd3;

  state_t             state_reg, state_next;
  logic [1:0]         layer_cnt_reg, layer_cnt_next;
  logic [1:0]         layers_reg, layers_next;
  logic               done_reg, done_next;
  logic               timeout_reg, timeout_next;
  logic [3:0]         digit_reg, digit_next;
  logic [15:0]        result_score_reg, result_score_next;
  logic signed [15:0] max_score_reg, max_score_next;
  logic [3:0]         max_idx_reg, max_idx_next;
  logic               max_valid_reg, max_valid_next;

  logic wr_en;
  logic ctrl_wr;
  logic busy;
  logic beat_ok;
  logic beat_wins;
  logic set_done;
  logic set_timeout;
  logic clear_flags;
  logic wdog_expired;
  logic unused_writedata;

  assign wr_en            = chipselect && !write_n;
  assign ctrl_wr          = wr_en && (address == ADDR_CTRL);
  assign busy             = (state_reg != IDLE);
  assign beat_ok          = score_valid && (score_idx <= 4'd9);
  // First accepted beat always seeds the max; later beats need a strictly larger score.
  assign beat_wins        = !max_valid_reg || (score > max_score_reg);
  assign unused_writedata = ^writedata[31:2];

`ifdef INFER_TIMEOUT_EN
  logic [15:0] wdog_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_reg <= 16'd0;
    end else if (state_reg == START) begin
      wdog_reg <= 16'd0;
    end else if ((state_reg == WAIT) || (state_reg == ARGMAX)) begin
      wdog_reg <= wdog_reg + 16'd1;
    end
  end

  assign wdog_expired = ((state_reg == WAIT) || (state_reg == ARGMAX)) && (wdog_reg == 16'hFFFF);
`else
  assign wdog_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    layer_cnt_next    = layer_cnt_reg;
    digit_next        = digit_reg;
    result_score_next = result_score_reg;
    max_score_next    = max_score_reg;
    max_idx_next      = max_idx_reg;
    max_valid_next    = max_valid_reg;
    acc_start         = 1'b0;
    set_done          = 1'b0;
    set_timeout       = 1'b0;
    clear_flags       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (ctrl_wr && writedata[0]) begin
          state_next     = START;
          layer_cnt_next = 2'd0;
          clear_flags    = 1'b1;
        end
      end
      START: begin
        acc_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (acc_done) begin
          if (layer_cnt_reg < layers_reg) begin
            layer_cnt_next = layer_cnt_reg + 2'd1;
            state_next     = START;
          end else begin
            max_valid_next = 1'b0;
            state_next     = ARGMAX;
          end
        end
      end
      ARGMAX: begin
        if (beat_ok) begin
          if (beat_wins) begin
            max_score_next = score;
            max_idx_next   = score_idx;
            max_valid_next = 1'b1;
          end
          if (score_idx == 4'd9) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        digit_next        = max_idx_reg;
        result_score_next = max_score_reg;
        set_done          = 1'b1;
        state_next        = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Watchdog abort leaves the digit and RESULT untouched.
    if (wdog_expired) begin
      state_next  = IDLE;
      set_timeout = 1'b1;
    end
  end

  // A flag being set in the same cycle as a clear request keeps the flag set.
  always_comb begin
    done_next    = done_reg;
    timeout_next = timeout_reg;
    if (clear_flags || (ctrl_wr && writedata[1])) begin
      done_next    = 1'b0;
      timeout_next = 1'b0;
    end
    if (set_done) begin
      done_next = 1'b1;
    end
    if (set_timeout) begin
      timeout_next = 1'b1;
    end
  end

  always_comb begin
    layers_next = layers_reg;
    if (wr_en && (address == ADDR_LAYERS) && !busy) begin
      layers_next = writedata[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      layer_cnt_reg    <= 2'd0;
      layers_reg       <= 2'd2;
      done_reg         <= 1'b0;
      timeout_reg      <= 1'b0;
      digit_reg        <= 4'd0;
      result_score_reg <= 16'd0;
      max_score_reg    <= 16'sd0;
      max_idx_reg      <= 4'd0;
      max_valid_reg    <= 1'b0;
    end else begin
      layer_cnt_reg    <= layer_cnt_next;
      layers_reg       <= layers_next;
      done_reg         <= done_next;
      timeout_reg      <= timeout_next;
      digit_reg        <= digit_next;
      result_score_reg <= result_score_next;
      max_score_reg    <= max_score_next;
      max_idx_reg      <= max_idx_next;
      max_valid_reg    <= max_valid_next;
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL:   readdata = 32'd0;
      ADDR_STATUS: readdata = {29'd0, timeout_reg, done_reg, busy};
      ADDR_RESULT: readdata = {result_score_reg, 12'd0, digit_reg};
      ADDR_LAYERS: readdata = {30'd0, layers_reg};
      default:     readdata = 32'd0;
    endcase
  end

  assign acc_layer = layer_cnt_reg;
  assign digit_out = digit_reg;
  assign irq       = done_reg || timeout_reg;

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed self-checking bench for inference_sequencer: layer sequencing, argmax, flags, reset abort, watchdog.
module tb_inference_sequencer;

  logic               clk;
  logic               reset;
  logic [1:0]         address;
  logic               chipselect;
  logic               write_n;
  logic [31:0]        writedata;
  logic [31:0]        readdata;
  logic               acc_start;
  logic [1:0]         acc_layer;
  logic               acc_done;
  logic               score_valid;
  logic [3:0]         score_idx;
  logic signed [15:0] score;
  logic [3:0]         digit_out;
  logic               irq;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;

  inference_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .acc_start   (acc_start),
    .acc_layer   (acc_layer),
    .acc_done    (acc_done),
    .score_valid (score_valid),
    .score_idx   (score_idx),
    .score       (score),
    .digit_out   (digit_out),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (acc_start) start_cnt++;
  end

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  // Accelerator model: answer each acc_start with acc_done 5 cycles later.
  task automatic do_layers(input int n, output logic [7:0] seq, output int got);
    bit seen;
    seq = 8'd0;
    got = 0;
    for (int i = 0; i < n; i++) begin
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
        if (acc_start) seen = 1'b1;
        else @(negedge clk);
      end
      if (!seen) return;
      seq = {seq[5:0], acc_layer};
      got++;
      repeat (4) @(negedge clk);
      acc_done = 1'b1;
      @(negedge clk);
      acc_done = 1'b0;
    end
  endtask

  task automatic send_scores(input logic [159:0] sc, input bit extra);
    for (int i = 0; i < 10; i++) begin
      if (extra && i == 5) begin
        score_valid = 1'b1; score_idx = 4'd12; score = 16'sh7FFF;
        @(negedge clk);
      end
      score_valid = 1'b1; score_idx = 4'(i); score = sc[i*16 +: 16];
      @(negedge clk);
    end
    score_valid = 1'b0; score_idx = 4'd0; score = 16'sd0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    address = 2'd1;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (readdata[0] == 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (acc_start !== 1'b0) begin bad++; $display("FAIL reset_acc_start: got %b expected 0", acc_start); end
    total++; if (acc_layer !== 2'd0) begin bad++; $display("FAIL reset_acc_layer: got %0d expected 0", acc_layer); end
    total++; if (digit_out !== 4'd0) begin bad++; $display("FAIL reset_digit: got %0d expected 0", digit_out); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
    read_reg(2'd1, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_status: got %h expected 00000000", d); end
    read_reg(2'd2, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_result: got %h expected 00000000", d); end
    read_reg(2'd3, d);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL reset_layers: got %h expected 00000002", d); end
    $display("reset released: status/result/layers read");
  endtask

  task automatic test_basic;
    logic [159:0] sc;
    logic [7:0] seq;
    logic [31:0] d;
    int got;
    bit ok;
    for (int i = 0; i < 10; i++) sc[i*16 +: 16] = 16'(10 * (i + 1));
    write_reg(2'd0, 32'd1);
    do_layers(3, seq, got);
    total++; if (got !== 3) begin bad++; $display("FAIL basic_layer_count: got %0d expected 3", got); end
    total++; if (seq !== 8'h06) begin bad++; $display("FAIL basic_layer_seq: got %h expected 06", seq); end
    send_scores(sc, 1'b0);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_idle: busy stuck, expected idle"); end
    total++; if (digit_out !== 4'd9) begin bad++; $display("FAIL basic_digit: got %0d expected 9", digit_out); end
    read_reg(2'd2, d);
    total++; if (d !== 32'h0064_0009) begin bad++; $display("FAIL basic_result: got %h expected 00640009", d); end
    read_reg(2'd1, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL basic_status: got %h expected 00000002", d); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL basic_irq: got %b expected 1", irq); end
    $display("inference basic: digit=%0d", digit_out);
  endtask

  task automatic test_clear;
    logic [31:0] d;
    write_reg(2'd2, 32'hFFFF_FFFF);
    read_reg(2'd2, d);
    total++; if (d !== 32'h0064_0009) begin bad++; $display("FAIL ro_result: got %h expected 00640009", d); end
    write_reg(2'd0, 32'd2);
    read_reg(2'd1, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL clear_status: got %h expected 00000000", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL clear_irq: got %b expected 0", irq); end
    total++; if (digit_out !== 4'd9) begin bad++; $display("FAIL clear_digit: got %0d expected 9", digit_out); end
    $display("clear flags: status=%h", d);
  endtask

  task automatic test_tie;
    logic [159:0] sc;
    logic [7:0] seq;
    logic [31:0] d;
    int got;
    bit ok;
    sc = '0;
    sc[3*16 +: 16] = 16'd500;
    sc[7*16 +: 16] = 16'd500;
    write_reg(2'd0, 32'd1);
    do_layers(3, seq, got);
    send_scores(sc, 1'b0);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL tie_idle: busy stuck, expected idle"); end
    total++; if (digit_out !== 4'd3) begin bad++; $display("FAIL tie_digit: got %0d expected 3", digit_out); end
    read_reg(2'd2, d);
    total++; if (d !== 32'h01F4_0003) begin bad++; $display("FAIL tie_result: got %h expected 01f40003", d); end
    $display("inference tie: digit=%0d", digit_out);
  endtask

  task automatic test_signed_ignore;
    logic [159:0] sc;
    logic [7:0] seq;
    logic [31:0] d;
    int got;
    bit ok;
    sc[0*16 +: 16] = 16'(-50); sc[1*16 +: 16] = 16'(-40); sc[2*16 +: 16] = 16'(-30);
    sc[3*16 +: 16] = 16'(-20); sc[4*16 +: 16] = 16'(-10); sc[5*16 +: 16] = 16'(-60);
    sc[6*16 +: 16] = 16'(-1);  sc[7*16 +: 16] = 16'(-70); sc[8*16 +: 16] = 16'(-80);
    sc[9*16 +: 16] = 16'(-90);
    write_reg(2'd0, 32'd1);
    read_reg(2'd1, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL start_clears_done: got %h expected 00000001", d); end
    do_layers(3, seq, got);
    send_scores(sc, 1'b1);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL signed_idle: busy stuck, expected idle"); end
    total++; if (digit_out !== 4'd6) begin bad++; $display("FAIL signed_digit: got %0d expected 6", digit_out); end
    read_reg(2'd2, d);
    total++; if (d !== 32'hFFFF_0006) begin bad++; $display("FAIL signed_result: got %h expected ffff0006", d); end
    $display("inference signed+idx12: digit=%0d", digit_out);
  endtask

  task automatic test_busy_start;
    logic [159:0] sc;
    logic [7:0] seq;
    logic [31:0] d;
    int got;
    int c0;
    bit ok;
    for (int i = 0; i < 10; i++) sc[i*16 +: 16] = 16'(100 - 10 * i);
    c0 = start_cnt;
    write_reg(2'd0, 32'd1);
    fork
      do_layers(3, seq, got);
      begin
        repeat (2) @(negedge clk);
        write_reg(2'd0, 32'd1);
        write_reg(2'd3, 32'd0);
      end
    join
    total++; if (got !== 3) begin bad++; $display("FAIL busy_layer_count: got %0d expected 3", got); end
    total++; if (seq !== 8'h06) begin bad++; $display("FAIL busy_layer_seq: got %h expected 06", seq); end
    send_scores(sc, 1'b0);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL busy_idle: busy stuck, expected idle"); end
    total++; if (start_cnt - c0 !== 3) begin bad++; $display("FAIL busy_start_pulses: got %0d expected 3", start_cnt - c0); end
    read_reg(2'd3, d);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL busy_layers_write: got %h expected 00000002", d); end
    total++; if (digit_out !== 4'd0) begin bad++; $display("FAIL busy_digit: got %0d expected 0", digit_out); end
    read_reg(2'd2, d);
    total++; if (d !== 32'h0064_0000) begin bad++; $display("FAIL busy_result: got %h expected 00640000", d); end
    $display("inference busy-start: digit=%0d", digit_out);
  endtask

  task automatic test_layers_two;
    logic [159:0] sc;
    logic [7:0] seq;
    logic [31:0] d;
    int got;
    bit ok;
    for (int i = 0; i < 10; i++) sc[i*16 +: 16] = 16'd7;
    sc[4*16 +: 16] = 16'h1234;
    write_reg(2'd3, 32'd1);
    read_reg(2'd3, d);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL layers_write: got %h expected 00000001", d); end
    write_reg(2'd0, 32'd1);
    do_layers(2, seq, got);
    total++; if (seq !== 8'h01) begin bad++; $display("FAIL layers2_seq: got %h expected 01", seq); end
    send_scores(sc, 1'b0);
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL layers2_idle: busy stuck, expected idle"); end
    total++; if (digit_out !== 4'd4) begin bad++; $display("FAIL layers2_digit: got %0d expected 4", digit_out); end
    read_reg(2'd2, d);
    total++; if (d !== 32'h1234_0004) begin bad++; $display("FAIL layers2_result: got %h expected 12340004", d); end
    $display("inference two layers: digit=%0d", digit_out);
  endtask

  task automatic test_watchdog;
    logic [31:0] d;
    bit ok;
    write_reg(2'd0, 32'd2);
    write_reg(2'd0, 32'd1);
`ifdef INFER_TIMEOUT_EN
    ok = 1'b0;
    address = 2'd1;
    for (int k = 0; k < 70000 && !ok; k++) begin
      @(negedge clk);
      if (readdata[0] == 1'b0) ok = 1'b1;
    end
    total++; if (!ok) begin bad++; $display("FAIL wdog_abort: busy stuck, expected timeout abort"); end
    read_reg(2'd1, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL wdog_status: got %h expected 00000004", d); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL wdog_irq: got %b expected 1", irq); end
`else
    ok = 1'b1;
    repeat (300) @(negedge clk);
    read_reg(2'd1, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL nowdog_status: got %h expected 00000001", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL nowdog_irq: got %b expected 0", irq); end
`endif
    total++; if (digit_out !== 4'd4) begin bad++; $display("FAIL wdog_digit: got %0d expected 4", digit_out); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    $display("stalled inference: status=%h", d);
  endtask

  task automatic test_mid_reset;
    logic [7:0] seq;
    logic [31:0] d;
    int got;
    int c0;
    write_reg(2'd3, 32'd1);
    c0 = start_cnt;
    write_reg(2'd0, 32'd1);
    do_layers(1, seq, got);
    @(negedge clk);
    total++; if (acc_layer !== 2'd1) begin bad++; $display("FAIL midrst_pre_layer: got %0d expected 1", acc_layer); end
    reset = 1'b1;
    #1;
    total++; if (acc_layer !== 2'd0) begin bad++; $display("FAIL midrst_acc_layer: got %0d expected 0", acc_layer); end
    total++; if (acc_start !== 1'b0) begin bad++; $display("FAIL midrst_acc_start: got %b expected 0", acc_start); end
    total++; if (digit_out !== 4'd0) begin bad++; $display("FAIL midrst_digit: got %0d expected 0", digit_out); end
    @(negedge clk); reset = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (start_cnt - c0 !== 2) begin bad++; $display("FAIL midrst_no_start: got %0d expected 2", start_cnt - c0); end
    read_reg(2'd1, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL midrst_status: got %h expected 00000000", d); end
    read_reg(2'd3, d);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL midrst_layers: got %h expected 00000002", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL midrst_irq: got %b expected 0", irq); end
    $display("mid-inference reset: status=%h", d);
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1;
    address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    acc_done = 1'b0; score_valid = 1'b0; score_idx = 4'd0; score = 16'sd0;
    test_reset();
    test_basic();
    test_clear();
    test_tie();
    test_signed_ignore();
    test_busy_start();
    test_layers_two();
    test_watchdog();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
